// File: rtl/fsic_as_is_arbiter.sv
// Round-robin sequencer sharing the as_is_* stream between AXI-Lite write, AXI-Lite read and
// user AXIS packets. Optional outstanding-read credit limit: define FSIC_ARB_RD_LIMIT_EN.
module fsic_as_is_arbiter #(
   parameter int pADDR_WIDTH         = 28,
   parameter int pDATA_WIDTH         = 32,
   parameter int pMAX_RD_OUTSTANDING = 4
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   cc_is_enable,
   input  logic                   wr_req_valid,
   input  logic [pADDR_WIDTH-1:0] wr_req_addr,
   input  logic [3:0]             wr_req_be,
   input  logic [pDATA_WIDTH-1:0] wr_req_data,
   output logic                   wr_req_ready,
   input  logic                   rd_req_valid,
   input  logic [pADDR_WIDTH-1:0] rd_req_addr,
   output logic                   rd_req_ready,
   input  logic [pDATA_WIDTH-1:0] st_tdata,
   input  logic [3:0]             st_tstrb,
   input  logic [3:0]             st_tkeep,
   input  logic                   st_tlast,
   input  logic                   st_tvalid,
   output logic                   st_tready,
   input  logic                   rd_cpl,
   output logic [pDATA_WIDTH-1:0] as_is_tdata,
   output logic [3:0]             as_is_tstrb,
   output logic [3:0]             as_is_tkeep,
   output logic                   as_is_tlast,
   output logic [1:0]             as_is_tid,
   output logic [1:0]             as_is_tuser,
   output logic                   as_is_tvalid,
   input  logic                   is_as_tready,
   output logic [3:0]             rd_outstanding
);

   typedef enum logic [1:0] {IDLE = 2'd0, WR_DATA = 2'd1, STREAM = 2'd2} state_t;

   state_t                 state_r, state_nxt_s;
   logic [1:0]             rr_r, rr_nxt_s, win_s;
   logic [pDATA_WIDTH-1:0] wr_data_r;
   logic                   load_s, rd_ok_s, grant_ok_s;
   logic                   wr_grant_s, rd_grant_s, st_ready_s;
   logic                   beat_vld_s, beat_last_s;
   logic [pDATA_WIDTH-1:0] beat_data_s;
   logic [3:0]             beat_strb_s, beat_keep_s;
   logic [1:0]             beat_tid_s, beat_tuser_s;

   // First requester at or after ptr wins; 3 means nobody
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [1:0] win;
      win = 2'd3;
      case (ptr)
         2'd0:    win = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
         2'd1:    win = req[1] ? 2'd1 : req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd3;
         2'd2:    win = req[2] ? 2'd2 : req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd3;
         default: win = 2'd3;
      endcase
      return win;
   endfunction

   assign load_s     = !as_is_tvalid || is_as_tready;
   assign grant_ok_s = load_s && cc_is_enable && !axis_rst && (state_r == IDLE);
   assign win_s      = grant_ok_s ? rr_pick({st_tvalid, rd_req_valid && rd_ok_s, wr_req_valid}, rr_r)
                                  : 2'd3;

   assign wr_req_ready = wr_grant_s;
   assign rd_req_ready = rd_grant_s;
   assign st_tready    = st_ready_s;

   // Next-state, grant pulses and the beat presented to the output register
   always_comb begin
      state_nxt_s  = state_r;
      rr_nxt_s     = rr_r;
      wr_grant_s   = 1'b0;
      rd_grant_s   = 1'b0;
      st_ready_s   = 1'b0;
      beat_vld_s   = 1'b0;
      beat_data_s  = {pDATA_WIDTH{1'b0}};
      beat_strb_s  = 4'h0;
      beat_keep_s  = 4'h0;
      beat_last_s  = 1'b0;
      beat_tid_s   = 2'b00;
      beat_tuser_s = 2'b00;
      case (state_r)
         IDLE: begin
            case (win_s)
               2'd0: begin
                  wr_grant_s   = 1'b1;
                  beat_vld_s   = 1'b1;
                  beat_data_s  = {wr_req_be, wr_req_addr};
                  beat_strb_s  = 4'hF;
                  beat_keep_s  = 4'hF;
                  beat_last_s  = 1'b1;
                  beat_tid_s   = 2'b01;
                  beat_tuser_s = 2'b01;
                  state_nxt_s  = WR_DATA;
                  rr_nxt_s     = 2'd1;
               end
               2'd1: begin
                  rd_grant_s   = 1'b1;
                  beat_vld_s   = 1'b1;
                  beat_data_s  = {4'hF, rd_req_addr};
                  beat_strb_s  = 4'hF;
                  beat_keep_s  = 4'hF;
                  beat_last_s  = 1'b1;
                  beat_tid_s   = 2'b01;
                  beat_tuser_s = 2'b10;
                  state_nxt_s  = IDLE;
                  rr_nxt_s     = 2'd2;
               end
               2'd2: begin
                  st_ready_s   = 1'b1;
                  beat_vld_s   = 1'b1;
                  beat_data_s  = st_tdata;
                  beat_strb_s  = st_tstrb;
                  beat_keep_s  = st_tkeep;
                  beat_last_s  = st_tlast;
                  rr_nxt_s     = 2'd0;
                  if (st_tlast) begin
                     state_nxt_s = IDLE;
                  end else begin
                     state_nxt_s = STREAM;
                  end
               end
               default: begin
                  state_nxt_s = IDLE;
               end
            endcase
         end
         WR_DATA: begin
            if (load_s) begin
               beat_vld_s   = 1'b1;
               beat_data_s  = wr_data_r;
               beat_strb_s  = 4'hF;
               beat_keep_s  = 4'hF;
               beat_last_s  = 1'b1;
               beat_tid_s   = 2'b01;
               beat_tuser_s = 2'b01;
               state_nxt_s  = IDLE;
            end else begin
               state_nxt_s = WR_DATA;
            end
         end
         STREAM: begin
            st_ready_s = load_s && !axis_rst;
            if (st_ready_s && st_tvalid) begin
               beat_vld_s  = 1'b1;
               beat_data_s = st_tdata;
               beat_strb_s = st_tstrb;
               beat_keep_s = st_tkeep;
               beat_last_s = st_tlast;
               if (st_tlast) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = STREAM;
               end
            end else begin
               state_nxt_s = STREAM;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Sequencer state, round-robin pointer and latched write data
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_r   <= IDLE;
         rr_r      <= 2'd0;
         wr_data_r <= {pDATA_WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         rr_r    <= rr_nxt_s;
         if (wr_grant_s) begin
            wr_data_r <= wr_req_data;
         end
      end
   end

   // Output register: payload only moves when a beat is loaded, so a stall holds it stable
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         as_is_tvalid <= 1'b0;
         as_is_tdata  <= {pDATA_WIDTH{1'b0}};
         as_is_tstrb  <= 4'h0;
         as_is_tkeep  <= 4'h0;
         as_is_tlast  <= 1'b0;
         as_is_tid    <= 2'b00;
         as_is_tuser  <= 2'b00;
      end else if (load_s) begin
         as_is_tvalid <= beat_vld_s;
         if (beat_vld_s) begin
            as_is_tdata <= beat_data_s;
            as_is_tstrb <= beat_strb_s;
            as_is_tkeep <= beat_keep_s;
            as_is_tlast <= beat_last_s;
            as_is_tid   <= beat_tid_s;
            as_is_tuser <= beat_tuser_s;
         end
      end
   end

`ifdef FSIC_ARB_RD_LIMIT_EN
   localparam logic [3:0] RD_MAX = 4'(pMAX_RD_OUTSTANDING);
   logic [3:0] rd_cnt_r;
   logic       rd_dec_s;

   assign rd_dec_s       = rd_cpl && (rd_cnt_r != 4'd0);
   assign rd_ok_s        = (rd_cnt_r < RD_MAX);
   assign rd_outstanding = rd_cnt_r;

   // Read credits: grant takes one, completion returns one, both together cancel
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         rd_cnt_r <= 4'd0;
      end else if (rd_grant_s && !rd_dec_s) begin
         rd_cnt_r <= rd_cnt_r + 4'd1;
      end else if (!rd_grant_s && rd_dec_s) begin
         rd_cnt_r <= rd_cnt_r - 4'd1;
      end
   end
`else
   logic unused_rd_s;

   assign rd_ok_s        = 1'b1;
   assign rd_outstanding = 4'd0;
   assign unused_rd_s    = rd_cpl ^ (pMAX_RD_OUTSTANDING > 32'sd0);
`endif

endmodule
